// File: rtl/wisc_pkg.sv
// Shared WISC pipeline constants, opcode encodings and fetch-state type.
package wisc_pkg;
  localparam int PC_W    = 16;
  localparam int INSTR_W = 16;
  localparam int PC_INC  = 2;

  localparam logic [3:0] OP_LW  = 4'h8;
  localparam logic [3:0] OP_SW  = 4'h9;
  localparam logic [3:0] OP_LLB = 4'hA;
  localparam logic [3:0] OP_LHB = 4'hB;
  localparam logic [3:0] OP_B   = 4'hC;
  localparam logic [3:0] OP_BR  = 4'hD;
  localparam logic [3:0] OP_PCS = 4'hE;
  localparam logic [3:0] OP_HLT = 4'hF;

  typedef enum logic {
    FETCH = 1'b0,
    HALT  = 1'b1
  } fetch_state_t;
endpackage

// File: rtl/if_id_reg.sv
// Pipeline register with load enable, flush and async reset; flush clears only
// the valid bit so payload keeps its last value.
module if_id_reg #(
  parameter int PC_W    = 16,
  parameter int INSTR_W = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               load_en,
  input  logic               flush,
  input  logic [INSTR_W-1:0] instr_in,
  input  logic [PC_W-1:0]    pc_plus2_in,
  output logic [INSTR_W-1:0] instr,
  output logic [PC_W-1:0]    pc_plus2,
  output logic               valid
);
  logic [INSTR_W-1:0] instr_q, instr_d;
  logic [PC_W-1:0]    pc_plus2_q, pc_plus2_d;
  logic               valid_q, valid_d;

  // flush outranks a held load: a redirect must kill the slot even when stalled
  always_comb begin
    instr_d    = instr_q;
    pc_plus2_d = pc_plus2_q;
    valid_d    = valid_q;
    if (flush) begin
      valid_d = 1'b0;
    end else if (load_en) begin
      instr_d    = instr_in;
      pc_plus2_d = pc_plus2_in;
      valid_d    = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      instr_q    <= '0;
      pc_plus2_q <= '0;
      valid_q    <= 1'b0;
    end else begin
      instr_q    <= instr_d;
      pc_plus2_q <= pc_plus2_d;
      valid_q    <= valid_d;
    end
  end

  assign instr    = instr_q;
  assign pc_plus2 = pc_plus2_q;
  assign valid    = valid_q;
endmodule

// File: rtl/fetch_stage.sv
// WISC instruction-fetch stage: owns the PC, handles stall/redirect/HLT, and
// feeds the IF/ID register.
//   state | meaning
//   FETCH | requesting imem[pc] every cycle
//   HALT  | HLT fetched; no requests until a taken branch redirects
module fetch_stage #(
  parameter int             PC_W     = 16,
  parameter int             INSTR_W  = 16,
  parameter logic [PC_W-1:0] RESET_PC = '0
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               stall,
  input  logic               branch_taken,
  input  logic [PC_W-1:0]    branch_target,
  output logic [PC_W-1:0]    imem_addr,
  output logic               imem_rd,
  input  logic [INSTR_W-1:0] imem_data,
  input  logic               imem_valid,
  output logic [INSTR_W-1:0] ifid_instr,
  output logic [PC_W-1:0]    ifid_pc_plus2,
  output logic               ifid_valid,
  output logic [3:0]         opcode,
  output logic               halted
);
  import wisc_pkg::*;

  fetch_state_t    state_q, state_d;
  logic [PC_W-1:0] pc_q, pc_d;
  logic            halted_q, halted_d;
  logic            imem_rd_q, imem_rd_d;
  logic [PC_W-1:0] pc_plus2;
  logic            fetch_ok;
  logic            is_hlt;

  assign pc_plus2 = pc_q + PC_W'(PC_INC);
  assign fetch_ok = (state_q == FETCH) && imem_valid;
  assign is_hlt   = (imem_data[INSTR_W-1 -: 4] == OP_HLT);

  always_comb begin
    pc_d    = pc_q;
    state_d = state_q;
    if (branch_taken) begin
      pc_d    = branch_target;
      state_d = FETCH;
    end else if (!stall && fetch_ok) begin
      // HLT parks the PC on itself so the halted address stays visible
      if (is_hlt) state_d = HALT;
      else        pc_d    = pc_plus2;
    end
    halted_d  = (state_d == HALT);
    imem_rd_d = (state_d == FETCH);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc_q      <= RESET_PC;
      state_q   <= FETCH;
      halted_q  <= 1'b0;
      imem_rd_q <= 1'b1;
    end else begin
      pc_q      <= pc_d;
      state_q   <= state_d;
      halted_q  <= halted_d;
      imem_rd_q <= imem_rd_d;
    end
  end

  if_id_reg #(
    .PC_W    (PC_W),
    .INSTR_W (INSTR_W)
  ) u_if_id (
    .clk         (clk),
    .rst         (rst),
    .load_en     (!stall),
    .flush       (branch_taken || (!stall && !fetch_ok)),
    .instr_in    (imem_data),
    .pc_plus2_in (pc_plus2),
    .instr       (ifid_instr),
    .pc_plus2    (ifid_pc_plus2),
    .valid       (ifid_valid)
  );

  assign imem_addr = pc_q;
  assign imem_rd   = imem_rd_q;
  assign halted    = halted_q;
  assign opcode    = ifid_instr[INSTR_W-1 -: 4];
endmodule

// File: tb/tb_fetch_stage.sv
// Self-checking bench for fetch_stage: directed vector table, async-reset
// sequences, and randomized traffic against a behavioural model.
module tb_fetch_stage;
  logic        clk = 1'b0;
  logic        rst;
  logic        stall, branch_taken, imem_valid;
  logic [15:0] branch_target, imem_data;
  logic [15:0] imem_addr, ifid_instr, ifid_pc_plus2;
  logic        imem_rd, ifid_valid, halted;
  logic [3:0]  opcode;

  int checks = 0;
  int errors = 0;

  fetch_stage #(.PC_W(16), .INSTR_W(16), .RESET_PC(16'h0000)) dut (
    .clk(clk), .rst(rst), .stall(stall), .branch_taken(branch_taken),
    .branch_target(branch_target), .imem_addr(imem_addr), .imem_rd(imem_rd),
    .imem_data(imem_data), .imem_valid(imem_valid), .ifid_instr(ifid_instr),
    .ifid_pc_plus2(ifid_pc_plus2), .ifid_valid(ifid_valid), .opcode(opcode),
    .halted(halted)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        st, br;
    logic [15:0] tgt;
    logic        iv;
    logic [15:0] data;
    logic [15:0] e_addr;
    logic        e_rd, e_valid;
    logic [15:0] e_instr, e_pp2;
    logic        e_halt;
  } vec_t;

  vec_t vecs[17];

  // behavioural reference state
  logic [15:0] m_pc, m_instr, m_pp2;
  logic        m_valid, m_halt;

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_outputs(input string tag, input logic [15:0] e_addr, input logic e_rd,
                               input logic e_valid, input logic [15:0] e_instr,
                               input logic [15:0] e_pp2, input logic e_halt);
    check({tag, ".addr"},   imem_addr,     e_addr);
    check({tag, ".rd"},     16'(imem_rd),  16'(e_rd));
    check({tag, ".valid"},  16'(ifid_valid), 16'(e_valid));
    check({tag, ".instr"},  ifid_instr,    e_instr);
    check({tag, ".pp2"},    ifid_pc_plus2, e_pp2);
    check({tag, ".opcode"}, 16'(opcode),   16'(e_instr[15:12]));
    check({tag, ".halted"}, 16'(halted),   16'(e_halt));
  endtask

  task automatic model_reset();
    m_pc = 16'h0000; m_instr = 16'h0000; m_pp2 = 16'h0000;
    m_valid = 1'b0; m_halt = 1'b0;
  endtask

  // priority rules: branch, stall, halt, wait, fetch
  task automatic model_step(input logic st, input logic br, input logic [15:0] tgt,
                            input logic iv, input logic [15:0] data);
    if (br) begin
      m_pc = tgt; m_valid = 1'b0; m_halt = 1'b0;
    end else if (st) begin
    end else if (m_halt || !iv) begin
      m_valid = 1'b0;
    end else begin
      m_instr = data; m_pp2 = m_pc + 16'd2; m_valid = 1'b1;
      if (data[15:12] == 4'hF) m_halt = 1'b1;
      else m_pc = m_pc + 16'd2;
    end
  endtask

  task automatic drive(input logic st, input logic br, input logic [15:0] tgt,
                       input logic iv, input logic [15:0] data);
    stall = st; branch_taken = br; branch_target = tgt; imem_valid = iv; imem_data = data;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    drive(0, 0, 16'h0, 0, 16'h0);
    #1;
    model_reset();
    check_outputs("reset", 16'h0000, 1'b1, 1'b0, 16'h0000, 16'h0000, 1'b0);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  function automatic vec_t mk(logic st, logic br, logic [15:0] tgt, logic iv, logic [15:0] data,
                              logic [15:0] ea, logic er, logic ev, logic [15:0] ei,
                              logic [15:0] ep, logic eh);
    vec_t v;
    v.st = st; v.br = br; v.tgt = tgt; v.iv = iv; v.data = data;
    v.e_addr = ea; v.e_rd = er; v.e_valid = ev; v.e_instr = ei; v.e_pp2 = ep; v.e_halt = eh;
    return v;
  endfunction

  initial begin
    logic [15:0] d, t;
    logic s, b, v;

    //            st br tgt      iv data      addr     rd vl instr    pp2      halt
    vecs[0]  = mk(0, 0, 16'h0000, 1, 16'h1234, 16'h0002, 1, 1, 16'h1234, 16'h0002, 0);
    vecs[1]  = mk(0, 0, 16'h0000, 1, 16'h2345, 16'h0004, 1, 1, 16'h2345, 16'h0004, 0);
    vecs[2]  = mk(1, 0, 16'h0000, 1, 16'h3456, 16'h0004, 1, 1, 16'h2345, 16'h0004, 0);
    vecs[3]  = mk(1, 0, 16'h0000, 1, 16'h3456, 16'h0004, 1, 1, 16'h2345, 16'h0004, 0);
    vecs[4]  = mk(1, 0, 16'h0000, 1, 16'h3456, 16'h0004, 1, 1, 16'h2345, 16'h0004, 0);
    vecs[5]  = mk(0, 0, 16'h0000, 1, 16'h3456, 16'h0006, 1, 1, 16'h3456, 16'h0006, 0);
    vecs[6]  = mk(1, 1, 16'h0040, 1, 16'h4567, 16'h0040, 1, 0, 16'h3456, 16'h0006, 0);
    vecs[7]  = mk(0, 0, 16'h0000, 0, 16'h9999, 16'h0040, 1, 0, 16'h3456, 16'h0006, 0);
    vecs[8]  = mk(0, 0, 16'h0000, 0, 16'h9999, 16'h0040, 1, 0, 16'h3456, 16'h0006, 0);
    vecs[9]  = mk(0, 0, 16'h0000, 1, 16'h5000, 16'h0042, 1, 1, 16'h5000, 16'h0042, 0);
    vecs[10] = mk(0, 1, 16'h0010, 1, 16'hF000, 16'h0010, 1, 0, 16'h5000, 16'h0042, 0);
    vecs[11] = mk(0, 0, 16'h0000, 1, 16'hF000, 16'h0010, 0, 1, 16'hF000, 16'h0012, 1);
    vecs[12] = mk(0, 0, 16'h0000, 1, 16'h1111, 16'h0010, 0, 0, 16'hF000, 16'h0012, 1);
    vecs[13] = mk(0, 1, 16'h0020, 0, 16'h0000, 16'h0020, 1, 0, 16'hF000, 16'h0012, 0);
    vecs[14] = mk(0, 0, 16'h0000, 1, 16'h7777, 16'h0022, 1, 1, 16'h7777, 16'h0022, 0);
    vecs[15] = mk(0, 1, 16'hFFFE, 0, 16'h0000, 16'hFFFE, 1, 0, 16'h7777, 16'h0022, 0);
    vecs[16] = mk(0, 0, 16'h0000, 1, 16'h8888, 16'h0000, 1, 1, 16'h8888, 16'h0000, 0);

    do_reset();
    for (int i = 0; i < 17; i++) begin
      drive(vecs[i].st, vecs[i].br, vecs[i].tgt, vecs[i].iv, vecs[i].data);
      @(posedge clk);
      @(negedge clk);
      check_outputs($sformatf("vec%0d", i), vecs[i].e_addr, vecs[i].e_rd, vecs[i].e_valid,
                    vecs[i].e_instr, vecs[i].e_pp2, vecs[i].e_halt);
    end

    // async reset while waiting on imem
    drive(0, 0, 16'h0, 0, 16'h0);
    @(posedge clk);
    #2 rst = 1'b1;
    #1 check_outputs("rst_wait", 16'h0000, 1'b1, 1'b0, 16'h0000, 16'h0000, 1'b0);
    @(negedge clk);
    rst = 1'b0;

    // async reset while halted and stalled
    drive(0, 0, 16'h0, 1, 16'hF123);
    @(posedge clk);
    @(negedge clk);
    check_outputs("halt_pre", 16'h0000, 1'b0, 1'b1, 16'hF123, 16'h0002, 1'b1);
    drive(1, 0, 16'h0, 1, 16'h0000);
    @(posedge clk);
    #2 rst = 1'b1;
    #1 check_outputs("rst_halt", 16'h0000, 1'b1, 1'b0, 16'h0000, 16'h0000, 1'b0);
    @(negedge clk);
    rst = 1'b0;

    // randomized traffic against the model
    do_reset();
    for (int i = 0; i < 400; i++) begin
      s = ($urandom_range(3) == 0);
      b = ($urandom_range(7) == 0);
      v = ($urandom_range(3) != 0);
      t = ($urandom_range(5) == 0) ? 16'hFFFE : 16'($urandom);
      d = 16'($urandom);
      if ($urandom_range(9) == 0) d[15:12] = 4'hF;
      drive(s, b, t, v, d);
      model_step(s, b, t, v, d);
      @(posedge clk);
      @(negedge clk);
      check_outputs($sformatf("rnd%0d", i), m_pc, !m_halt, m_valid, m_instr, m_pp2, m_halt);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
